// File: rtl/vid_timing_pkg.sv
// Shared constants for the raster timing generator: raster presets,
// scan-mode constants and counter width helpers.
package vid_timing_pkg;

  // Scan modes
  localparam int PROGRESSIVE = 0;
  localparam int INTERLACED  = 1;

  // 1080i60 (SMPTE 274M interlaced)
  localparam int P1080I60_H_ACTIVE   = 1920;
  localparam int P1080I60_H_TOTAL    = 2200;
  localparam int P1080I60_V_ACTIVE   = 1080;
  localparam int P1080I60_V_TOTAL    = 1125;
  localparam int P1080I60_V_F1_START = 563;

  // 720p60 (SMPTE 296M progressive)
  localparam int P720P60_H_ACTIVE    = 1280;
  localparam int P720P60_H_TOTAL     = 1650;
  localparam int P720P60_V_ACTIVE    = 720;
  localparam int P720P60_V_TOTAL     = 750;

  // 525i (SD interlaced)
  localparam int P525I_H_ACTIVE      = 720;
  localparam int P525I_H_TOTAL       = 858;
  localparam int P525I_V_ACTIVE      = 486;
  localparam int P525I_V_TOTAL       = 525;
  localparam int P525I_V_F1_START    = 263;

  // Bits needed to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold 0..max inclusive, never narrower than one bit.
  function automatic int max_width(input int max);
    return cnt_width(max + 1);
  endfunction

endpackage

// File: rtl/vtg_wrap_counter.sv
// Wrapping counter 0..MAX with increment, synchronous clear and a wrap
// strobe. Resets and clears to MAX so the first increment lands on 0.
// o_next exposes the value the counter takes on the coming edge so the
// parent can decode registered flags aligned with the count.
module vtg_wrap_counter #(
  parameter int MAX = 7,
  parameter int W   = 3
) (
  input  logic         clk_400_000,
  input  logic         RESET,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_next,
  output logic         o_wrap_out
);

  localparam logic [W-1:0] L_MAX = W'(MAX);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max   = (r_count == L_MAX);
  assign o_wrap_out = i_inc & w_at_max;
  assign o_count    = r_count;

  // Next value: clear wins over increment; increment wraps MAX -> 0.
  always_comb begin
    o_next = r_count;
    if (i_clr) begin
      o_next = L_MAX;
    end else if (i_inc) begin
      o_next = w_at_max ? '0 : r_count + 1'b1;
    end
  end

  // Count register with asynchronous reset to MAX.
  always_ff @(posedge clk_400_000 or posedge RESET) begin
    if (RESET) begin
      r_count <= L_MAX;
    end else begin
      r_count <= o_next;
    end
  end

endmodule

// File: rtl/vid_timing_gen.sv
// Raster timing generator. Advances one pixel per qualified clock enable
// (ce & enable & locked) and produces registered position, blanking,
// field and pulse outputs that are all aligned with h_count/v_count.
// Dropping locked forces everything back to reset values on the next edge.
module vid_timing_gen #(
  parameter int H_ACTIVE   = 1920,
  parameter int H_TOTAL    = 2200,
  parameter int V_ACTIVE   = 1080,
  parameter int V_TOTAL    = 1125,
  parameter int INTERLACED = 1,
  parameter int V_F1_START = 563,
  parameter int FC_W       = 32
) (
  input  logic                       RESET,
  input  logic                       clk_400_000,
  input  logic                       locked,
  input  logic                       enable,
  input  logic                       ce,
  output logic [$clog2(H_TOTAL)-1:0] h_count,
  output logic [$clog2(V_TOTAL)-1:0] v_count,
  output logic                       active,
  output logic                       hblank,
  output logic                       vblank,
  output logic                       field,
  output logic                       sof,
  output logic                       eol,
  output logic [FC_W-1:0]            frame_count
);

  import vid_timing_pkg::*;

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam bit L_IL = (INTERLACED != PROGRESSIVE);

  // Decode thresholds held at 32 bits so the field-1 end line may equal
  // V_TOTAL without overflowing the line counter width.
  localparam logic [31:0] L_HA     = 32'(H_ACTIVE);
  localparam logic [31:0] L_VA     = 32'(V_ACTIVE);
  localparam logic [31:0] L_VA_F   = 32'(V_ACTIVE / 2);
  localparam logic [31:0] L_F1     = 32'(V_F1_START);
  localparam logic [31:0] L_F1_END = 32'(V_F1_START + V_ACTIVE / 2);

  // Reject impossible rasters at elaboration.
  if (H_ACTIVE >= H_TOTAL) begin : g_bad_h
    $error("vid_timing_gen: H_ACTIVE must be less than H_TOTAL");
  end
  if (V_ACTIVE >= V_TOTAL) begin : g_bad_v
    $error("vid_timing_gen: V_ACTIVE must be less than V_TOTAL");
  end
  if ((INTERLACED != 0) && (V_F1_START + V_ACTIVE / 2 > V_TOTAL)) begin : g_bad_f1
    $error("vid_timing_gen: field 1 runs past V_TOTAL");
  end

  logic          w_adv;
  logic          w_clr;
  logic [HW-1:0] w_h_count;
  logic [HW-1:0] w_h_next;
  logic          w_h_wrap;
  logic [VW-1:0] w_v_count;
  logic [VW-1:0] w_v_next;
  logic          w_v_wrap;
  logic [31:0]   w_h32;
  logic [31:0]   w_v32;
  logic          w_hblank_nx;
  logic          w_vblank_nx;
  logic          w_field_nx;

  logic            r_hblank;
  logic            r_vblank;
  logic            r_active;
  logic            r_field;
  logic            r_sof;
  logic            r_eol;
  logic [FC_W-1:0] r_frame_count;

  assign w_adv = ce & enable & locked;
  assign w_clr = ~locked;

  vtg_wrap_counter #(
    .MAX (H_TOTAL - 1),
    .W   (HW)
  ) u_h_cnt (
    .clk_400_000 (clk_400_000),
    .RESET       (RESET),
    .i_clr       (w_clr),
    .i_inc       (w_adv),
    .o_count     (w_h_count),
    .o_next      (w_h_next),
    .o_wrap_out  (w_h_wrap)
  );

  // The line counter steps only when the pixel counter wraps on an advance.
  vtg_wrap_counter #(
    .MAX (V_TOTAL - 1),
    .W   (VW)
  ) u_v_cnt (
    .clk_400_000 (clk_400_000),
    .RESET       (RESET),
    .i_clr       (w_clr),
    .i_inc       (w_h_wrap),
    .o_count     (w_v_count),
    .o_next      (w_v_next),
    .o_wrap_out  (w_v_wrap)
  );

  assign w_h32 = 32'(w_h_next);
  assign w_v32 = 32'(w_v_next);

  // Blanking and field decode of the position the counters are moving to.
  always_comb begin
    w_hblank_nx = (w_h32 >= L_HA);
    w_vblank_nx = (w_v32 >= L_VA);
    w_field_nx  = 1'b0;
    if (L_IL) begin
      w_vblank_nx = ~((w_v32 < L_VA_F) | ((w_v32 >= L_F1) & (w_v32 < L_F1_END)));
      w_field_nx  = (w_v32 >= L_F1);
    end
  end

  // Flag and frame-counter registers; pulses clear on any non-advance edge.
  always_ff @(posedge clk_400_000 or posedge RESET) begin
    if (RESET) begin
      r_hblank      <= 1'b1;
      r_vblank      <= 1'b1;
      r_active      <= 1'b0;
      r_field       <= L_IL;
      r_sof         <= 1'b0;
      r_eol         <= 1'b0;
      r_frame_count <= '0;
    end else if (!locked) begin
      r_hblank      <= 1'b1;
      r_vblank      <= 1'b1;
      r_active      <= 1'b0;
      r_field       <= L_IL;
      r_sof         <= 1'b0;
      r_eol         <= 1'b0;
      r_frame_count <= '0;
    end else if (w_adv) begin
      r_hblank <= w_hblank_nx;
      r_vblank <= w_vblank_nx;
      r_active <= ~w_hblank_nx & ~w_vblank_nx;
      r_field  <= w_field_nx;
      r_sof    <= w_v_wrap;
      r_eol    <= w_h_wrap;
      if (w_v_wrap) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
    end else begin
      r_sof <= 1'b0;
      r_eol <= 1'b0;
    end
  end

  assign h_count     = w_h_count;
  assign v_count     = w_v_count;
  assign active      = r_active;
  assign hblank      = r_hblank;
  assign vblank      = r_vblank;
  assign field       = r_field;
  assign sof         = r_sof;
  assign eol         = r_eol;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: a progressive 8x4 raster (FC_W=2) and an
// interlaced 8x10 raster driven by the same controls, each compared every
// cycle against a position-from-advance-count model, plus literal checks.
module tb_vid_timing_gen;

  // Clock / reset block
  logic clk_400_000 = 1'b0;
  logic RESET;
  logic locked;
  logic enable;
  logic ce;

  always #5 clk_400_000 = ~clk_400_000;

  // Progressive DUT outputs
  logic [2:0] p_h;
  logic [1:0] p_v;
  logic       p_active, p_hblank, p_vblank, p_field, p_sof, p_eol;
  logic [1:0] p_fc;

  // Interlaced DUT outputs
  logic [2:0] i_h;
  logic [3:0] i_v;
  logic       i_active, i_hblank, i_vblank, i_field, i_sof, i_eol;
  logic [7:0] i_fc;

  vid_timing_gen #(
    .H_ACTIVE(6), .H_TOTAL(8), .V_ACTIVE(3), .V_TOTAL(4),
    .INTERLACED(0), .V_F1_START(0), .FC_W(2)
  ) u_prog (
    .RESET(RESET), .clk_400_000(clk_400_000), .locked(locked),
    .enable(enable), .ce(ce), .h_count(p_h), .v_count(p_v),
    .active(p_active), .hblank(p_hblank), .vblank(p_vblank),
    .field(p_field), .sof(p_sof), .eol(p_eol), .frame_count(p_fc)
  );

  vid_timing_gen #(
    .H_ACTIVE(6), .H_TOTAL(8), .V_ACTIVE(6), .V_TOTAL(10),
    .INTERLACED(1), .V_F1_START(5), .FC_W(8)
  ) u_intl (
    .RESET(RESET), .clk_400_000(clk_400_000), .locked(locked),
    .enable(enable), .ce(ce), .h_count(i_h), .v_count(i_v),
    .active(i_active), .hblank(i_hblank), .vblank(i_vblank),
    .field(i_field), .sof(i_sof), .eol(i_eol), .frame_count(i_fc)
  );

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the whole raster state is a count of advances since
  // the last reset; position, flags and frame number follow arithmetically.
  typedef struct packed {
    int h;
    int v;
    bit active;
    bit hblank;
    bit vblank;
    bit field;
    bit sof;
    bit eol;
    int fc;
  } exp_t;

  int m_n    = 0;    // advances since reset
  bit m_padv = 1'b0; // the last edge was an advance

  always @(posedge clk_400_000 or posedge RESET) begin
    if (RESET || !locked) begin
      m_n    = 0;
      m_padv = 1'b0;
    end else if (ce && enable) begin
      m_n    = m_n + 1;
      m_padv = 1'b1;
    end else begin
      m_padv = 1'b0;
    end
  end

  function automatic exp_t model(input int ht, input int ha, input int vt,
                                 input int va, input bit il, input int f1,
                                 input int fcw, input int n, input bit padv);
    exp_t e;
    int   fsz;
    int   idx;
    fsz = ht * vt;
    if (n == 0) begin
      e.h = ht - 1; e.v = vt - 1;
      e.hblank = 1'b1; e.vblank = 1'b1; e.active = 1'b0;
      e.field = il; e.sof = 1'b0; e.eol = 1'b0; e.fc = 0;
      return e;
    end
    idx      = (n - 1) % fsz;
    e.h      = idx % ht;
    e.v      = idx / ht;
    e.hblank = (e.h >= ha);
    if (il) begin
      e.vblank = !((e.v < va / 2) || ((e.v >= f1) && (e.v < f1 + va / 2)));
      e.field  = (e.v >= f1);
    end else begin
      e.vblank = (e.v >= va);
      e.field  = 1'b0;
    end
    e.active = !e.hblank && !e.vblank;
    e.sof    = padv && (idx == 0);
    e.eol    = padv && (e.h == 0);
    e.fc     = ((n - 1) / fsz + 1) % (1 << fcw);
    return e;
  endfunction

  // Scoreboard compare: both DUTs against the model on every falling edge.
  always @(negedge clk_400_000) begin
    exp_t ep;
    exp_t ei;
    if (started) begin
      ep = model(8, 6, 4, 3, 1'b0, 0, 2, m_n, m_padv);
      ei = model(8, 6, 10, 6, 1'b1, 5, 8, m_n, m_padv);
      check("p_h", int'(p_h), ep.h);
      check("p_v", int'(p_v), ep.v);
      check("p_active", int'(p_active), int'(ep.active));
      check("p_hblank", int'(p_hblank), int'(ep.hblank));
      check("p_vblank", int'(p_vblank), int'(ep.vblank));
      check("p_field", int'(p_field), int'(ep.field));
      check("p_sof", int'(p_sof), int'(ep.sof));
      check("p_eol", int'(p_eol), int'(ep.eol));
      check("p_fc", int'(p_fc), ep.fc);
      check("i_h", int'(i_h), ei.h);
      check("i_v", int'(i_v), ei.v);
      check("i_active", int'(i_active), int'(ei.active));
      check("i_hblank", int'(i_hblank), int'(ei.hblank));
      check("i_vblank", int'(i_vblank), int'(ei.vblank));
      check("i_field", int'(i_field), int'(ei.field));
      check("i_sof", int'(i_sof), int'(ei.sof));
      check("i_eol", int'(i_eol), int'(ei.eol));
      check("i_fc", int'(i_fc), ei.fc);
    end
  end

  // Driver: wait for the next rising edge, then settle 2 time units.
  // Inputs set after step() are consumed by the following edge.
  task automatic step();
    @(posedge clk_400_000);
    #2;
  endtask

  task automatic set_ctl(input bit c, input bit en, input bit lk);
    ce     = c;
    enable = en;
    locked = lk;
  endtask

  initial begin
    bit   found;
    exp_t ep;

    RESET = 1'b1;
    set_ctl(1'b0, 1'b0, 1'b0);
    step();
    step();
    RESET   = 1'b0;
    started = 1'b1;
    step();

    // Reset values
    check("lit_reset_p_h", int'(p_h), 7);
    check("lit_reset_p_v", int'(p_v), 3);
    check("lit_reset_p_active", int'(p_active), 0);
    check("lit_reset_p_fc", int'(p_fc), 0);
    check("lit_reset_i_v", int'(i_v), 9);
    check("lit_reset_i_field", int'(i_field), 1);

    // First advance lands on (0,0) with sof, eol and active together
    set_ctl(1'b1, 1'b1, 1'b1);
    step();
    check("lit_first_h", int'(p_h), 0);
    check("lit_first_v", int'(p_v), 0);
    check("lit_first_sof", int'(p_sof), 1);
    check("lit_first_eol", int'(p_eol), 1);
    check("lit_first_active", int'(p_active), 1);
    check("lit_first_fc", int'(p_fc), 1);
    check("lit_first_i_field", int'(i_field), 0);

    // Continuous ce: 96 advances = three 32-pixel frames
    repeat (95) step();
    check("lit_96_fc", int'(p_fc), 3);
    check("lit_96_h", int'(p_h), 7);
    check("lit_96_v", int'(p_v), 3);
    repeat (32) step();
    check("lit_fc_wrap", int'(p_fc), 0);

    // Sparse ce: one advance per three clocks
    for (int i = 0; i < 90; i++) begin
      ce = (i % 3 == 0);
      step();
    end

    // Run to (h=3, v=1) on the progressive raster, then freeze for 20 clocks
    set_ctl(1'b1, 1'b1, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      ep = model(8, 6, 4, 3, 1'b0, 0, 2, m_n, m_padv);
      if (ep.h == 3 && ep.v == 1) found = 1'b1;
      else step();
    end
    check("enable_drop_reached", int'(found), 1);
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ce = 1'($urandom_range(0, 1));
      step();
      check("lit_frozen_sof", int'(p_sof), 0);
      check("lit_frozen_eol", int'(p_eol), 0);
    end
    check("lit_frozen_h", int'(p_h), 3);
    check("lit_frozen_v", int'(p_v), 1);
    set_ctl(1'b1, 1'b1, 1'b1);
    step();
    check("lit_resume_h", int'(p_h), 4);
    check("lit_resume_v", int'(p_v), 1);

    // Lock loss mid-frame
    repeat (13) step();
    locked = 1'b0;
    step();
    check("lit_unlock_h", int'(p_h), 7);
    check("lit_unlock_v", int'(p_v), 3);
    check("lit_unlock_fc", int'(p_fc), 0);
    check("lit_unlock_hblank", int'(p_hblank), 1);
    locked = 1'b1;
    step();
    check("lit_relock_h", int'(p_h), 0);
    check("lit_relock_v", int'(p_v), 0);
    check("lit_relock_sof", int'(p_sof), 1);
    check("lit_relock_fc", int'(p_fc), 1);

    // Asynchronous reset mid-frame
    repeat (21) step();
    RESET = 1'b1;
    #1;
    check("lit_async_h", int'(p_h), 7);
    check("lit_async_fc", int'(p_fc), 0);
    step();
    RESET = 1'b0;
    step();
    check("lit_after_reset_sof", int'(p_sof), 1);
    check("lit_after_reset_fc", int'(p_fc), 1);

    // Randomised run with occasional lock loss
    for (int i = 0; i < 400; i++) begin
      ce     = 1'($urandom_range(0, 3) != 0);
      enable = 1'($urandom_range(0, 7) != 0);
      locked = 1'($urandom_range(0, 59) != 0);
      step();
    end

    started = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
